// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared vis-signal, status and arbiter FSM encodings
package mem_arbiter_pkg;

    typedef logic [1:0] vis_signal_t;
    typedef logic [1:0] mem_status_t;

    // Request encodings seen by the caches and MAIN_MEMORY; 2'b11 is treated as NONE
    localparam vis_signal_t SIG_NONE  = 2'b00;
    localparam vis_signal_t SIG_READ  = 2'b01;
    localparam vis_signal_t SIG_WRITE = 2'b10;

    // Status encodings returned to the caches and by MAIN_MEMORY
    localparam mem_status_t STAT_IDLE = 2'b00;
    localparam mem_status_t STAT_BUSY = 2'b01;
    localparam mem_status_t STAT_DONE = 2'b10;

    // Arbiter FSM states
    localparam logic [1:0] ARB_IDLE    = 2'b00;
    localparam logic [1:0] ARB_GRANT_I = 2'b01;
    localparam logic [1:0] ARB_GRANT_D = 2'b10;
    localparam logic [1:0] ARB_RELEASE = 2'b11;

    // Identity of the cache granted most recently (round-robin history)
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    function automatic logic sig_is_req(input vis_signal_t sig);
        return (sig == SIG_READ) || (sig == SIG_WRITE);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational I/D winner select, fixed-priority or round-robin (MEM_ARB_RR_EN)
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic       i_req,
    input  logic       d_req,
`ifdef MEM_ARB_RR_EN
    input  logic       rr_last,
`else
    input  logic [3:0] wait_cnt,
`endif
    output logic       grant_i,
    output logic       grant_d
);

`ifndef MEM_ARB_RR_EN
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
`endif

    // Single requester always wins; a tie is resolved by the configured policy
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            if (rr_last == OWNER_D) begin
                grant_i = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
`else
            if (wait_cnt >= MAX_WAIT_C) begin
                grant_i = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
`endif
        end else begin
            grant_i = i_req;
            grant_d = d_req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D-cache main-memory port arbiter; MEM_ARB_RR_EN selects round-robin ties
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH       = 17,
    parameter int LEN              = 32,
    parameter int ENTRY_INDEX_SIZE = 3,
    parameter int MAX_WAIT         = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  i_cache_mem_vis_signal,
    input  logic [ADDR_WIDTH-1:0]       i_cache_mem_vis_addr,
    output logic [LEN-1:0]              i_cache_mem_data,
    output logic [1:0]                  i_cache_mem_status,
    input  logic [1:0]                  d_cache_mem_vis_signal,
    input  logic [ADDR_WIDTH-1:0]       d_cache_mem_vis_addr,
    input  logic [LEN-1:0]              d_cache_writen_data,
    input  logic [ENTRY_INDEX_SIZE:0]   d_cache_write_length,
    output logic [LEN-1:0]              d_cache_mem_data,
    output logic [1:0]                  d_cache_mem_status,
    output logic [1:0]                  mem_vis_signal,
    output logic [ADDR_WIDTH-1:0]       mem_vis_addr,
    output logic [LEN-1:0]              mem_writen_data,
    output logic [ENTRY_INDEX_SIZE:0]   mem_write_length,
    input  logic [LEN-1:0]              mem_data,
    input  logic [1:0]                  mem_status
);

    logic [1:0] state;
    logic       i_req;
    logic       d_req;
    logic       grant_i;
    logic       grant_d;

    // The I-cache only ever reads; any other code from it is not a request
    assign i_req = (i_cache_mem_vis_signal == SIG_READ);
    assign d_req = sig_is_req(d_cache_mem_vis_signal);

`ifdef MEM_ARB_RR_EN
    logic rr_last;

    mem_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
        .i_req   (i_req),
        .d_req   (d_req),
        .rr_last (rr_last),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    // Remember who was granted last so the next tie goes to the other cache
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= OWNER_I;
        end else if (state == ARB_IDLE) begin
            if (grant_i) begin
                rr_last <= OWNER_I;
            end else if (grant_d) begin
                rr_last <= OWNER_D;
            end
        end
    end
`else
    logic [3:0] wait_cnt;

    mem_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
        .i_req    (i_req),
        .d_req    (d_req),
        .wait_cnt (wait_cnt),
        .grant_i  (grant_i),
        .grant_d  (grant_d)
    );

    // Count D wins over a waiting I; saturate so a long D burst cannot wrap the count back to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ARB_IDLE) begin
            if (grant_i) begin
                wait_cnt <= '0;
            end else if (grant_d && i_req && (wait_cnt != 4'hF)) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end
`endif

    // Grant FSM: latch the winner's request, hold it until memory reports DONE, then one release bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ARB_IDLE;
            mem_vis_signal   <= SIG_NONE;
            mem_vis_addr     <= '0;
            mem_writen_data  <= '0;
            mem_write_length <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_d) begin
                        mem_vis_signal   <= d_cache_mem_vis_signal;
                        mem_vis_addr     <= d_cache_mem_vis_addr;
                        mem_writen_data  <= d_cache_writen_data;
                        mem_write_length <= d_cache_write_length;
                        state            <= ARB_GRANT_D;
                    end else if (grant_i) begin
                        mem_vis_signal   <= SIG_READ;
                        mem_vis_addr     <= i_cache_mem_vis_addr;
                        mem_writen_data  <= '0;
                        mem_write_length <= '0;
                        state            <= ARB_GRANT_I;
                    end
                end
                ARB_GRANT_I, ARB_GRANT_D: begin
                    if (mem_status == STAT_DONE) begin
                        mem_vis_signal <= SIG_NONE;
                        state          <= ARB_RELEASE;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Route memory status/data to the owner; a requesting non-owner sees BUSY
    always_comb begin
        i_cache_mem_status = STAT_IDLE;
        d_cache_mem_status = STAT_IDLE;
        i_cache_mem_data   = '0;
        d_cache_mem_data   = '0;
        case (state)
            ARB_GRANT_I: begin
                i_cache_mem_status = mem_status;
                i_cache_mem_data   = mem_data;
                d_cache_mem_status = d_req ? STAT_BUSY : STAT_IDLE;
            end
            ARB_GRANT_D: begin
                d_cache_mem_status = mem_status;
                d_cache_mem_data   = mem_data;
                i_cache_mem_status = i_req ? STAT_BUSY : STAT_IDLE;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  i_sig;
    logic [16:0] i_addr;
    logic [31:0] i_data;
    logic [1:0]  i_stat;
    logic [1:0]  d_sig;
    logic [16:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wlen;
    logic [31:0] d_data;
    logic [1:0]  d_stat;
    logic [1:0]  mem_vis_signal;
    logic [16:0] mem_vis_addr;
    logic [31:0] mem_writen_data;
    logic [3:0]  mem_write_length;
    logic [31:0] mem_data;
    logic [1:0]  mem_status;

    int checks = 0;
    int errors = 0;

    int          lat = 3;
    int          cnt = 0;
    logic        force_done = 1'b0;
    logic [16:0] op_addr[$];
    logic [1:0]  op_sig[$];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk                    (clk),
        .rst                    (rst),
        .i_cache_mem_vis_signal (i_sig),
        .i_cache_mem_vis_addr   (i_addr),
        .i_cache_mem_data       (i_data),
        .i_cache_mem_status     (i_stat),
        .d_cache_mem_vis_signal (d_sig),
        .d_cache_mem_vis_addr   (d_addr),
        .d_cache_writen_data    (d_wdata),
        .d_cache_write_length   (d_wlen),
        .d_cache_mem_data       (d_data),
        .d_cache_mem_status     (d_stat),
        .mem_vis_signal         (mem_vis_signal),
        .mem_vis_addr           (mem_vis_addr),
        .mem_writen_data        (mem_writen_data),
        .mem_write_length       (mem_write_length),
        .mem_data               (mem_data),
        .mem_status             (mem_status)
    );

    // Main-memory model: BUSY for lat-1 cycles then DONE with data 0xA5A50000 | addr; logs each op start
    always @(negedge clk) begin
        if (rst) begin
            mem_status = 2'b00;
            mem_data   = 32'd0;
            cnt        = 0;
        end else if (force_done) begin
            mem_status = 2'b10;
        end else if (mem_vis_signal == 2'b01 || mem_vis_signal == 2'b10) begin
            if (cnt == 0) begin
                op_addr.push_back(mem_vis_addr);
                op_sig.push_back(mem_vis_signal);
            end
            cnt = cnt + 1;
            if (cnt >= lat) begin
                mem_status = 2'b10;
                mem_data   = 32'hA5A5_0000 | {15'd0, mem_vis_addr};
            end else begin
                mem_status = 2'b01;
                mem_data   = 32'd0;
            end
        end else begin
            mem_status = 2'b00;
            mem_data   = 32'd0;
            cnt        = 0;
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] exp_seq[6];
        logic [16:0] got;
        int          waited;

        rst = 1'b1;
        i_sig = 2'b00; i_addr = '0;
        d_sig = 2'b00; d_addr = '0; d_wdata = '0; d_wlen = '0;
        step();
        step();
        check("rst_mem_sig",  32'(mem_vis_signal),   32'h0);
        check("rst_mem_addr", 32'(mem_vis_addr),     32'h0);
        check("rst_mem_wd",   mem_writen_data,       32'h0);
        check("rst_mem_len",  32'(mem_write_length), 32'h0);
        check("rst_i_stat",   32'(i_stat),           32'h0);
        check("rst_d_stat",   32'(d_stat),           32'h0);
        check("rst_i_data",   i_data,                32'h0);
        check("rst_d_data",   d_data,                32'h0);
        rst = 1'b0;
        step();

        // I READ 0x10 alone
        i_sig = 2'b01; i_addr = 17'h00010;
        step();
        check("i1_mem_sig",  32'(mem_vis_signal), 32'h1);
        check("i1_mem_addr", 32'(mem_vis_addr),   32'h10);
        check("i1_stat_c1",  32'(i_stat),         32'h1);
        check("i1_d_stat",   32'(d_stat),         32'h0);
        step();
        check("i1_stat_c2",  32'(i_stat),         32'h1);
        step();
        check("i1_stat_c3",  32'(i_stat),         32'h2);
        check("i1_data",     i_data,              32'hA5A50010);
        i_sig = 2'b00;
        step();
        check("i1_rel_sig",  32'(mem_vis_signal), 32'h0);
        check("i1_rel_stat", 32'(i_stat),         32'h0);
        step();
        check("i1_idle_sig", 32'(mem_vis_signal), 32'h0);
        check("i1_ops",      32'(op_addr.size()), 32'd1);

        // DONE from memory while idle is ignored
        force_done = 1'b1;
        step();
        check("idone_i_stat", 32'(i_stat),         32'h0);
        check("idone_d_stat", 32'(d_stat),         32'h0);
        check("idone_sig",    32'(mem_vis_signal), 32'h0);
        force_done = 1'b0;
        step();
        check("idone_sig2",   32'(mem_vis_signal), 32'h0);

        // Simultaneous I READ 0x20 and D WRITE 0x100: D first, I waits
        i_sig = 2'b01; i_addr = 17'h00020;
        d_sig = 2'b10; d_addr = 17'h00100; d_wdata = 32'hDEADBEEF; d_wlen = 4'd4;
        step();
        check("tie_mem_sig",  32'(mem_vis_signal),   32'h2);
        check("tie_mem_addr", 32'(mem_vis_addr),     32'h100);
        check("tie_mem_wd",   mem_writen_data,       32'hDEADBEEF);
        check("tie_mem_len",  32'(mem_write_length), 32'h4);
        check("tie_d_stat",   32'(d_stat),           32'h1);
        check("tie_i_busy1",  32'(i_stat),           32'h1);
        step();
        check("tie_i_busy2",  32'(i_stat),           32'h1);
        step();
        check("tie_d_done",   32'(d_stat),           32'h2);
        check("tie_i_busy3",  32'(i_stat),           32'h1);
        d_sig = 2'b00;
        step();
        check("tie_rel_i",    32'(i_stat),           32'h0);
        check("tie_rel_sig",  32'(mem_vis_signal),   32'h0);
        step();
        check("tie_idle_sig", 32'(mem_vis_signal),   32'h0);
        step();
        check("tie_i_sig",    32'(mem_vis_signal),   32'h1);
        check("tie_i_addr",   32'(mem_vis_addr),     32'h20);
        check("tie_i_stat",   32'(i_stat),           32'h1);
        step();
        step();
        check("tie_i_done",   32'(i_stat),           32'h2);
        check("tie_i_data",   i_data,                32'hA5A50020);
        i_sig = 2'b00;
        step();
        step();
        check("tie_ops",      32'(op_addr.size()),   32'd3);

        // Both caches request continuously
        op_addr.delete();
        op_sig.delete();
`ifdef MEM_ARB_RR_EN
        exp_seq = '{17'h200, 17'h300, 17'h200, 17'h300, 17'h200, 17'h300};
`else
        exp_seq = '{17'h200, 17'h200, 17'h200, 17'h200, 17'h300, 17'h200};
`endif
        d_sig = 2'b01; d_addr = 17'h00200;
        i_sig = 2'b01; i_addr = 17'h00300;
        waited = 0;
        while (op_addr.size() < 6 && waited < 300) begin
            step();
            waited++;
        end
        check("cont_no_timeout", 32'(waited < 300), 32'd1);
        for (int k = 0; k < 6; k++) begin
            got = (k < op_addr.size()) ? op_addr[k] : 17'h1FFFF;
            check($sformatf("cont_grant%0d", k), 32'(got), 32'(exp_seq[k]));
        end
        d_sig = 2'b00;
        i_sig = 2'b00;
        for (int k = 0; k < 12; k++) step();
        check("cont_drained", 32'(mem_vis_signal), 32'h0);

        // D drops its request one cycle after grant
        op_addr.delete();
        op_sig.delete();
        d_sig = 2'b10; d_addr = 17'h00400; d_wdata = 32'h12345678; d_wlen = 4'd2;
        step();
        check("drop_sig0",  32'(mem_vis_signal), 32'h2);
        check("drop_addr",  32'(mem_vis_addr),   32'h400);
        d_sig = 2'b00;
        step();
        check("drop_sig1",  32'(mem_vis_signal), 32'h2);
        check("drop_wd",    mem_writen_data,     32'h12345678);
        check("drop_busy",  32'(d_stat),         32'h1);
        step();
        check("drop_done",  32'(d_stat),         32'h2);
        step();
        check("drop_rel",   32'(d_stat),         32'h0);
        check("drop_rsig",  32'(mem_vis_signal), 32'h0);
        step();
        step();
        check("drop_nosig", 32'(mem_vis_signal), 32'h0);
        check("drop_ops",   32'(op_addr.size()), 32'd1);

        // Reset while D owns memory
        d_sig = 2'b01; d_addr = 17'h00500;
        step();
        check("mrst_pre_sig",  32'(mem_vis_signal), 32'h1);
        check("mrst_pre_d",    32'(d_stat),         32'h1);
        rst = 1'b1;
        d_sig = 2'b00;
        step();
        check("mrst_sig",      32'(mem_vis_signal), 32'h0);
        check("mrst_addr",     32'(mem_vis_addr),   32'h0);
        check("mrst_d_stat",   32'(d_stat),         32'h0);
        check("mrst_i_stat",   32'(i_stat),         32'h0);
        rst = 1'b0;
        step();
        check("mrst_idle_sig", 32'(mem_vis_signal), 32'h0);
        i_sig = 2'b01; i_addr = 17'h00600;
        step();
        check("mrst_i_sig",    32'(mem_vis_signal), 32'h1);
        check("mrst_i_addr",   32'(mem_vis_addr),   32'h600);
        step();
        step();
        check("mrst_i_done",   32'(i_stat),         32'h2);
        check("mrst_i_data",   i_data,              32'hA5A50600);
        i_sig = 2'b00;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
